// File: rtl/pll_rst_seq_if.sv
// pll_rst_seq_if: lock interface between the PLL wrapper and the reset sequencer
interface pll_rst_seq_if #(parameter int NUM_RST = 3);
  logic               locked;
  logic               pll_rst;
  logic [NUM_RST-1:0] rst_n_out;
  logic               ready;
  logic               lock_lost;
  logic [7:0]         relock_cnt;
  modport master (input locked, output pll_rst, rst_n_out, ready, lock_lost, relock_cnt);
  modport slave (output locked, input pll_rst, rst_n_out, ready, lock_lost, relock_cnt);
endinterface

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset pulsing, lock qualification and staged downstream reset release
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int LOCK_STABLE    = 256,
  parameter int NUM_RST        = 3,
  parameter int STAGE_GAP      = 16
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  pll_rst_seq_if.master  bus
);
  localparam int CW = $clog2(PLL_RST_CYCLES + LOCK_TIMEOUT + LOCK_STABLE + STAGE_GAP);
  typedef enum logic [2:0] {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         sync_q;
  logic               locked_s;
  logic               pll_rst_q, pll_rst_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               lost_q, lost_d;
  logic [7:0]         relock_q, relock_d;
  assign locked_s = sync_q[1];
  // two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], bus.locked};
  // state, counter and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_q     <= '0;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      relock_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      rst_q     <= rst_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
      relock_q  <= relock_d;
    end
  // next state and next output values; lock loss after release begins takes priority
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    pll_rst_d = 1'b0;
    rst_d     = rst_q;
    ready_d   = ready_q;
    lost_d    = 1'b0;
    relock_d  = relock_q;
    case (state_q)
      S_PLL_RST: begin
        pll_rst_d = 1'b1;
        rst_d     = '0;
        ready_d   = 1'b0;
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        rst_d   = '0;
        ready_d = 1'b0;
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d   = S_PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          rst_d   = NUM_RST'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (!locked_s) begin
          state_d  = S_WAIT_LOCK;
          cnt_d    = '0;
          rst_d    = '0;
          ready_d  = 1'b0;
          lost_d   = 1'b1;
          relock_d = relock_q + 8'(relock_q != 8'hff);
        end else if (state_q == S_RELEASE && &rst_q) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end else if (state_q == S_RELEASE && cnt_q == CW'(STAGE_GAP - 1)) begin
          rst_d = (rst_q << 1) | NUM_RST'(1);
          cnt_d = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end
  assign bus.pll_rst    = pll_rst_q;
  assign bus.rst_n_out  = rst_q;
  assign bus.ready      = ready_q;
  assign bus.lock_lost  = lost_q;
  assign bus.relock_cnt = relock_q;
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: vector table, corner sequences and random lock patterns against a lock-streak model
module tb_pll_rst_seq;
  localparam int PRC = 4, TO = 64, LS = 16, NR = 3, GAP = 4;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  pll_rst_seq_if #(.NUM_RST(NR)) bus ();
  pll_rst_seq #(.PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS), .NUM_RST(NR), .STAGE_GAP(GAP))
    dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #10 sys_clk = ~sys_clk;
  int checks = 0, errors = 0, t = 0;
  // model: pulse edges left, consecutive unlocked waiting edges, consecutive synced-lock edges
  logic m_s1, m_s2, m_lost;
  int m_pulse, m_zeros, m_streak, m_relock;
  typedef struct packed {logic [7:0] at; logic pll; logic [NR-1:0] rst; logic rdy;} vec_t;
  vec_t vecs [10];
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, act, exp);
    end
  endtask
  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lost = 0;
    m_pulse = PRC; m_zeros = 0; m_streak = 0; m_relock = 0;
  endtask
  task automatic model_edge(input logic lk);
    logic ls;
    ls = m_s2; m_s2 = m_s1; m_s1 = lk;
    m_lost = 0;
    if (m_pulse > 0) begin
      m_pulse--; m_zeros = 0; m_streak = 0;
    end else if (ls) begin
      m_zeros = 0; m_streak++;
    end else begin
      if (m_streak >= LS + 1) begin
        m_lost = 1;
        if (m_relock < 255) m_relock++;
      end
      if (m_streak > 0) m_zeros = 0;
      else m_zeros++;
      m_streak = 0;
      if (m_zeros == TO) begin m_pulse = PRC; m_zeros = 0; end
    end
  endtask
  function automatic int exp_rst();
    int v = 0;
    for (int k = 0; k < NR; k++) if (m_streak >= LS + 1 + k * GAP) v |= 1 << k;
    return v;
  endfunction
  task automatic compare_all(input string tag);
    chk({tag, " pll_rst"}, int'(bus.pll_rst), int'(m_pulse > 0));
    chk({tag, " rst_n_out"}, int'(bus.rst_n_out), exp_rst());
    chk({tag, " ready"}, int'(bus.ready), int'(m_streak >= LS + 2 + (NR - 1) * GAP));
    chk({tag, " lock_lost"}, int'(bus.lock_lost), int'(m_lost));
    chk({tag, " relock_cnt"}, int'(bus.relock_cnt), m_relock);
  endtask
  task automatic step(input logic lk);
    bus.locked = lk;
    @(posedge sys_clk);
    model_edge(lk);
    @(negedge sys_clk);
    t++;
    compare_all("model");
  endtask
  task automatic run_to(input int n, input logic lk);
    while (t < n) step(lk);
  endtask
  task automatic do_reset();
    #5 sys_rst_n = 1'b0;
    #1 model_reset();
    compare_all("async_rst");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    t = 0;
  endtask
  initial begin
    logic lk;
    int len;
    vecs = '{'{8'd0, 1'b1, 3'b000, 1'b0}, '{8'd3, 1'b1, 3'b000, 1'b0}, '{8'd4, 1'b0, 3'b000, 1'b0},
             '{8'd28, 1'b0, 3'b000, 1'b0}, '{8'd29, 1'b0, 3'b001, 1'b0}, '{8'd32, 1'b0, 3'b001, 1'b0},
             '{8'd33, 1'b0, 3'b011, 1'b0}, '{8'd36, 1'b0, 3'b011, 1'b0}, '{8'd37, 1'b0, 3'b111, 1'b0},
             '{8'd38, 1'b0, 3'b111, 1'b1}};
    bus.locked = 1'b0;
    model_reset();
    #95 compare_all("reset");
    #5 sys_rst_n = 1'b1;
    // normal bring-up: lock first sampled at edge 11
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) step(i > 10);
      foreach (vecs[j]) if (int'(vecs[j].at) == i) begin
        chk("bringup pll_rst", int'(bus.pll_rst), int'(vecs[j].pll));
        chk("bringup rst_n_out", int'(bus.rst_n_out), int'(vecs[j].rst));
        chk("bringup ready", int'(bus.ready), int'(vecs[j].rdy));
      end
    end
    chk("bringup relock_cnt", int'(bus.relock_cnt), 0);
    // loss in RUN: locked low for edges 46..65
    run_to(45, 1'b1);
    run_to(47, 1'b0);
    chk("run_loss pre rst_n_out", int'(bus.rst_n_out), 7);
    chk("run_loss pre ready", int'(bus.ready), 1);
    step(1'b0);
    chk("run_loss rst_n_out", int'(bus.rst_n_out), 0);
    chk("run_loss ready", int'(bus.ready), 0);
    chk("run_loss lock_lost", int'(bus.lock_lost), 1);
    chk("run_loss relock_cnt", int'(bus.relock_cnt), 1);
    step(1'b0);
    chk("run_loss pulse width", int'(bus.lock_lost), 0);
    run_to(65, 1'b0);
    chk("run_loss pll_rst", int'(bus.pll_rst), 0);
    run_to(83, 1'b1);
    chk("rerelease pre", int'(bus.rst_n_out), 0);
    step(1'b1);
    chk("rerelease stage0", int'(bus.rst_n_out), 1);
    run_to(88, 1'b1);
    chk("rerelease stage1", int'(bus.rst_n_out), 3);
    // loss mid-RELEASE
    step(1'b0);
    step(1'b0);
    chk("rel_loss pre", int'(bus.rst_n_out), 3);
    step(1'b1);
    chk("rel_loss rst_n_out", int'(bus.rst_n_out), 0);
    chk("rel_loss lock_lost", int'(bus.lock_lost), 1);
    chk("rel_loss relock_cnt", int'(bus.relock_cnt), 2);
    run_to(100, 1'b1);
    // lock never asserts: pulses of 4 every 68 edges
    do_reset();
    for (int i = 1; i <= 140; i++) begin
      step(1'b0);
      chk("timeout pll_rst", int'(bus.pll_rst), int'((i % (PRC + TO)) < PRC));
      chk("timeout rst_n_out", int'(bus.rst_n_out), 0);
    end
    // unstable lock inside qualification
    do_reset();
    run_to(10, 1'b0);
    run_to(20, 1'b1);
    run_to(23, 1'b0);
    run_to(41, 1'b1);
    chk("unstable pre", int'(bus.rst_n_out), 0);
    chk("unstable relock_cnt", int'(bus.relock_cnt), 0);
    step(1'b1);
    chk("unstable release", int'(bus.rst_n_out), 1);
    // saturation of relock_cnt
    do_reset();
    for (int e = 0; e < 260; e++) begin
      repeat (30) step(1'b1);
      repeat (2) step(1'b0);
    end
    chk("saturate relock_cnt", int'(bus.relock_cnt), 255);
    repeat (40) step(1'b1);
    chk("mid_run ready", int'(bus.ready), 1);
    #5 sys_rst_n = 1'b0;
    #1 chk("async pll_rst", int'(bus.pll_rst), 1);
    chk("async rst_n_out", int'(bus.rst_n_out), 0);
    chk("async ready", int'(bus.ready), 0);
    chk("async relock_cnt", int'(bus.relock_cnt), 0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    t = 0;
    // random lock patterns with short glitches and long outages
    lk = 1'b0;
    while (t < 4000) begin
      lk = ~lk;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 90));
      repeat (len) step(lk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
